// File: rtl/conv3x3_frame_ctrl_if.sv
// Handshake, configuration and status bundle for the 3x3 convolution frame controller.
interface conv3x3_frame_ctrl_if #(
    parameter int unsigned CW = 12
);
    // Frame control and kernel configuration
    logic          i_start;
    logic [1:0]    i_cfg_mode;
    logic [31:0]   i_cfg_k0;
    logic [31:0]   i_cfg_k1;
    logic [31:0]   i_cfg_k2;

    // Pixel stream handshake
    logic          i_in_valid;
    logic          o_in_ready;
    logic          i_out_ready;

    // Line buffer / convolution core controls
    logic          o_lb_we;
    logic          o_conv_en;
    logic          o_out_valid;

    // Frame-latched kernel configuration
    logic [31:0]   o_reg0;
    logic [31:0]   o_reg1;
    logic [31:0]   o_reg2;
    logic [31:0]   o_reg3;

    // Raster position and status
    logic [CW-1:0] o_col;
    logic [CW-1:0] o_row;
    logic          o_busy;
    logic          o_frame_done;
    logic          o_err;

    // Controller side
    modport slave (
        input  i_start, i_cfg_mode, i_cfg_k0, i_cfg_k1, i_cfg_k2,
        input  i_in_valid, i_out_ready,
        output o_in_ready, o_lb_we, o_conv_en, o_out_valid,
        output o_reg0, o_reg1, o_reg2, o_reg3,
        output o_col, o_row, o_busy, o_frame_done, o_err
    );

    // Source / sink / host side
    modport master (
        output i_start, i_cfg_mode, i_cfg_k0, i_cfg_k1, i_cfg_k2,
        output i_in_valid, i_out_ready,
        input  o_in_ready, o_lb_we, o_conv_en, o_out_valid,
        input  o_reg0, o_reg1, o_reg2, o_reg3,
        input  o_col, o_row, o_busy, o_frame_done, o_err
    );
endinterface

// File: rtl/conv3x3_frame_ctrl.sv
// Frame sequencer for a 3x3 convolution pipeline: latches the kernel config at
// frame start, walks the raster, and gates line-buffer writes and core enables.
module conv3x3_frame_ctrl #(
    parameter int unsigned IMG_W = 640,
    parameter int unsigned IMG_H = 480,
    parameter int unsigned CW    = 12
) (
    input  logic                  iClk,
    input  logic                  iRst,
    conv3x3_frame_ctrl_if.slave   bus
);

    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
    localparam logic [CW-1:0] ROW_LAST  = CW'(IMG_H - 1);
    localparam logic [CW-1:0] WIN_FIRST = CW'(2);
    localparam logic [CW-1:0] FILL_COL  = CW'(1);
    localparam logic [CW-1:0] ONE       = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] row_q, row_d;
    logic [31:0]   reg0_q, reg0_d;
    logic [31:0]   reg1_q, reg1_d;
    logic [31:0]   reg2_q, reg2_d;
    logic [31:0]   reg3_q, reg3_d;
    logic          err_q, err_d;
    logic          frame_done_q, frame_done_d;
    logic          out_valid_q, out_valid_d;

    logic          in_ready;
    logic          acc;
    logic          conv_en;
    logic          col_wrap;
    logic          at_fill_end;
    logic          at_frame_end;

    // Handshake decode: a pixel is taken only while streaming and the sink can absorb a result
    always_comb begin
        in_ready     = 1'b0;
        acc          = 1'b0;
        conv_en      = 1'b0;
        col_wrap     = 1'b0;
        at_fill_end  = 1'b0;
        at_frame_end = 1'b0;

        if ((state_q == S_FILL) || (state_q == S_RUN)) begin
            in_ready = bus.i_out_ready;
        end
        acc          = bus.i_in_valid & in_ready;
        conv_en      = acc & (row_q >= WIN_FIRST) & (col_q >= WIN_FIRST);
        col_wrap     = (col_q == COL_LAST);
        at_fill_end  = (row_q == WIN_FIRST) && (col_q == FILL_COL);
        at_frame_end = (row_q == ROW_LAST) && (col_q == COL_LAST);
    end

    // Next-state, counter, config and status logic
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        reg0_d       = reg0_q;
        reg1_d       = reg1_q;
        reg2_d       = reg2_q;
        reg3_d       = reg3_q;
        err_d        = err_q;
        frame_done_d = 1'b0;
        out_valid_d  = conv_en;

        // Raster advance on every accepted pixel
        if (acc) begin
            if (col_wrap) begin
                col_d = '0;
                row_d = row_q + ONE;
            end else begin
                col_d = col_q + ONE;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    reg0_d  = {30'b0, bus.i_cfg_mode};
                    reg1_d  = bus.i_cfg_k0;
                    reg2_d  = bus.i_cfg_k1;
                    reg3_d  = bus.i_cfg_k2;
                    col_d   = '0;
                    row_d   = '0;
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (acc && at_fill_end) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (acc && at_frame_end) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Start in IDLE clears the sticky error; start anywhere else sets it (set wins)
        if (bus.i_start && (state_q == S_IDLE)) begin
            err_d = 1'b0;
        end
        if (bus.i_start && (state_q != S_IDLE)) begin
            err_d = 1'b1;
        end

        frame_done_d = (state_d == S_DONE);
    end

    // State register
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and status registers
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            col_q        <= '0;
            row_q        <= '0;
            reg0_q       <= '0;
            reg1_q       <= '0;
            reg2_q       <= '0;
            reg3_q       <= '0;
            err_q        <= 1'b0;
            frame_done_q <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            reg0_q       <= reg0_d;
            reg1_q       <= reg1_d;
            reg2_q       <= reg2_d;
            reg3_q       <= reg3_d;
            err_q        <= err_d;
            frame_done_q <= frame_done_d;
            out_valid_q  <= out_valid_d;
        end
    end

    // Output mapping
    assign bus.o_in_ready   = in_ready;
    assign bus.o_lb_we      = acc;
    assign bus.o_conv_en    = conv_en;
    assign bus.o_out_valid  = out_valid_q;
    assign bus.o_reg0       = reg0_q;
    assign bus.o_reg1       = reg1_q;
    assign bus.o_reg2       = reg2_q;
    assign bus.o_reg3       = reg3_q;
    assign bus.o_col        = col_q;
    assign bus.o_row        = row_q;
    assign bus.o_busy       = (state_q != S_IDLE);
    assign bus.o_frame_done = frame_done_q;
    assign bus.o_err        = err_q;

endmodule

// File: doc/conv3x3_frame_ctrl.md
CONV3X3_FRAME_CTRL -- requirements
Module: conv3x3_frame_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 640, pixels per line (>=3).
REQ-002 SHALL have parameter IMG_H, default 480, lines per frame (>=3).
REQ-003 SHALL have parameter CW, default 12, row/column counter width.
REQ-004 SHALL have ports, clock and reset first:
- iClk  in  1  the single clock; all state changes on its rising edge.
- iRst  in  1  asynchronous, active-high reset.
- i_start  in  1  one-cycle frame start request.
- i_cfg_mode  in  2  kernel select for the next frame.
- i_cfg_k0/k1/k2  in  32 each  custom kernel words K1-K4, K5-K8, K9 for the next frame.
- i_in_valid  in  1  source pixel valid.
- o_in_ready  out  1  controller accepts a pixel this cycle.
- i_out_ready  in  1  sink can take one result in the next cycle.
- o_lb_we  out  1  write the accepted pixel into the line buffer and shift the window.
- o_conv_en  out  1  drives the convolution core enable.
- o_reg0..o_reg3  out  32 each  frame-latched kernel config: o_reg0={30'b0,mode}, then k0, k1, k2.
- o_col, o_row  out  CW each  raster position of the pixel being accepted.
- o_out_valid  out  1  a convolution result is present this cycle.
- o_busy  out  1  high in any state except IDLE.
- o_frame_done  out  1  one-cycle end-of-frame pulse.
- o_err  out  1  sticky flag: i_start seen while busy.

Function
REQ-005 SHALL implement the FSM IDLE -> FILL -> RUN -> DRAIN -> DONE -> IDLE.
REQ-006 IDLE: i_start=1 SHALL latch i_cfg_* into o_reg0..3, clear o_col and o_row, and move to FILL; the o_reg* values SHALL NOT change again until the next accepted start.
REQ-007 Pixel accept SHALL be defined as acc = i_in_valid & o_in_ready.
- o_in_ready = i_out_ready while in FILL or RUN, otherwise 0 (combinational).
REQ-008 o_lb_we SHALL equal acc.
REQ-009 On acc, o_col SHALL increment and wrap from IMG_W-1 to 0, and o_row SHALL increment on that wrap.
REQ-010 FILL SHALL move to RUN on the acc at which o_row=2 and o_col=1, so the next acc completes the first full window.
REQ-011 o_conv_en SHALL be combinational: acc & (o_row>=2) & (o_col>=2).
- This gives exactly (IMG_W-2)*(IMG_H-2) enables per frame.
- Columns 0-1 of every line and rows 0-1 produce no enable.
REQ-012 o_out_valid SHALL be o_conv_en delayed by one register, matching the core's 1-cycle latency.
REQ-013 The sink SHALL accept every o_out_valid.
- Backpressure applies only through i_out_ready gating o_in_ready one cycle ahead.
REQ-014 RUN SHALL move to DRAIN on the acc with o_row=IMG_H-1 and o_col=IMG_W-1.
REQ-015 DRAIN SHALL last exactly 1 cycle, during which the final o_out_valid is issued, then move to DONE.
REQ-016 DONE SHALL assert o_frame_done for exactly 1 cycle, then return to IDLE.
REQ-017 i_start in any state other than IDLE SHALL be ignored and SHALL set o_err.
- o_err SHALL clear on the next start accepted in IDLE.
REQ-018 When i_start and an error condition occur in the same cycle, set SHALL take priority over clear (unreachable in practice, since start in IDLE is never an error).
REQ-019 Gaps (i_in_valid=0 or i_out_ready=0) SHALL freeze the counters and the state, with no enable.
REQ-020 Counters SHALL be unsigned and CW bits wide; CW SHALL satisfy 2^CW > max(IMG_W, IMG_H).

Reset
REQ-021 iRst=1 SHALL asynchronously force:
- state IDLE;
- o_reg0..3, o_col, o_row = 0;
- the o_out_valid register, o_err, o_frame_done = 0.
REQ-022 During reset the combinational outputs o_in_ready, o_lb_we and o_conv_en SHALL be 0.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no o_frame_done pulse; the next frame SHALL require a new i_start.

Verification
REQ-024 Use IMG_W=5, IMG_H=4; start with i_cfg_mode=1; stream 20 pixels with valid and ready held high ->
- 6 o_conv_en pulses, at (2,2),(2,3),(2,4),(3,2),(3,3),(3,4);
- each o_out_valid 1 cycle after its enable;
- o_frame_done 2 cycles after the last acc;
- o_reg0=1.
REQ-025 Same frame with i_out_ready toggled every cycle -> still exactly 6 results, no pixel accepted while ready is low, and counters hold during gaps.
REQ-026 Change i_cfg_mode and i_cfg_k* mid-frame -> o_reg* unchanged until the next start, which latches the new values.
REQ-027 Pulse i_start during RUN -> frame continues unaffected and o_err=1; next start from IDLE -> o_err=0.
REQ-028 Assert iRst after 10 accepted pixels -> immediately IDLE with all outputs 0 and no o_frame_done; a new start then yields a full 6-result frame.
REQ-029 Start with i_cfg_mode=3 and k0=32'h04030201 -> o_reg0=3 and o_reg1=32'h04030201 from the cycle after start.
